// File: rtl/lms_tone_source.sv
// lms_tone_source: multi-channel table-driven tone source for the LMS test path.
// Each channel walks a loadable one-period table; samples stream with a tone mix.
module lms_tone_source #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 500,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tbl_we,
  input  logic [ADDR_W-1:0]        tbl_addr,
  input  logic [DATA_W-1:0]        tbl_data,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_step,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_phase,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     start,
  input  logic                     stop,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NUM_CH*DATA_W-1:0] m_ch,
  output logic [DATA_W-1:0]        m_mix,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int LOG_CH = $clog2(NUM_CH);
  localparam int SUM_W  = DATA_W + LOG_CH;
  localparam int IW     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [NUM_CH*ADDR_W-1:0]  idx_q, idx_d;
  logic [NUM_CH*ADDR_W-1:0]  step_q, step_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;
  logic                      last_q, last_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [NUM_CH*DATA_W-1:0]  ch_q, ch_d;
  logic [DATA_W-1:0]         mix_q, mix_d;

  logic [DATA_W-1:0]         mem [DEPTH];

  logic [NUM_CH*ADDR_W-1:0]  src_idx, src_step, nxt_idx;
  logic [NUM_CH*DATA_W-1:0]  rd;
  logic [SUM_W-1:0]          sum;
  logic [ADDR_W:0]           wide;
  logic                      cfg_ok;
  logic [LEN_W-1:0]          cnt_inc, lenv;
  logic                      do_load;

  assign busy = (state_q == RUN);

  // Table write port, locked out while a burst is running.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy && ({1'b0, tbl_addr} < DEPTH_X))
      mem[tbl_addr[IW-1:0]] <= tbl_data;
  end

  // Fetch path; in IDLE it reads the start phase so the first
  // sample can be loaded on the start edge itself.
  always_comb begin
    src_idx  = (state_q == IDLE) ? cfg_phase : idx_q;
    src_step = (state_q == IDLE) ? cfg_step  : step_q;
    rd       = '0;
    sum      = '0;
    nxt_idx  = '0;
    wide     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd[i*DATA_W +: DATA_W] = mem[src_idx[i*ADDR_W +: IW]];
      sum  = sum + SUM_W'(rd[i*DATA_W +: DATA_W]);
      wide = {1'b0, src_idx[i*ADDR_W +: ADDR_W]}
           + {1'b0, src_step[i*ADDR_W +: ADDR_W]};
      if (wide >= DEPTH_X)
        wide = wide - DEPTH_X;
      nxt_idx[i*ADDR_W +: ADDR_W] = wide[ADDR_W-1:0];
    end
  end

  // Start is only legal when every step and phase lies inside the table.
  always_comb begin
    cfg_ok = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if ({1'b0, cfg_step[i*ADDR_W +: ADDR_W]} >= DEPTH_X ||
          {1'b0, cfg_phase[i*ADDR_W +: ADDR_W]} >= DEPTH_X)
        cfg_ok = 1'b0;
    end
  end

  // Burst FSM and sample load decisions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ch_d    = ch_q;
    mix_d   = mix_q;
    do_load = 1'b0;
    cnt_inc = (state_q == IDLE) ? LEN_W'(1) : cnt_q + LEN_W'(1);
    lenv    = (state_q == IDLE) ? cfg_len : len_q;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (cfg_ok) begin
            state_d = RUN;
            step_d  = cfg_step;
            len_d   = cfg_len;
            err_d   = 1'b0;
            do_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid_q && m_ready && last_q) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (stop) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if ((!valid_q || m_ready) && !last_q) begin
          do_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_load) begin
      ch_d    = rd;
      mix_d   = DATA_W'(sum >> LOG_CH);
      valid_d = 1'b1;
      idx_d   = nxt_idx;
      cnt_d   = cnt_inc;
      last_d  = (lenv != '0) && (cnt_inc == lenv);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ch_q    <= '0;
      mix_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ch_q    <= ch_d;
      mix_q   <= mix_d;
    end
  end

  assign m_valid = valid_q;
  assign m_ch    = ch_q;
  assign m_mix   = mix_q;
  assign done    = done_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_lms_tone_source.sv
// tb_lms_tone_source: directed bench with a sample-index stream model.
// Channel n-th sample = table[(phase + n*step) mod DEPTH].
module tb_lms_tone_source;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 500;
  localparam int ADDR_W = 10;
  localparam int NUM_CH = 2;
  localparam int LEN_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic                     tbl_we;
  logic [ADDR_W-1:0]        tbl_addr;
  logic [DATA_W-1:0]        tbl_data;
  logic [NUM_CH*ADDR_W-1:0] cfg_step;
  logic [NUM_CH*ADDR_W-1:0] cfg_phase;
  logic [LEN_W-1:0]         cfg_len;
  logic                     start;
  logic                     stop;
  logic                     m_valid;
  logic                     m_ready;
  logic [NUM_CH*DATA_W-1:0] m_ch;
  logic [DATA_W-1:0]        m_mix;
  logic                     busy;
  logic                     done;
  logic                     cfg_err;

  lms_tone_source #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cfg_step(cfg_step), .cfg_phase(cfg_phase), .cfg_len(cfg_len),
    .start(start), .stop(stop),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_ch(m_ch), .m_mix(m_mix),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  int checks = 0;
  int passed = 0;

  int tbl_m [DEPTH];
  int m_ph  [NUM_CH];
  int m_st  [NUM_CH];
  int m_len;
  int acc_n;
  int done_cnt;
  bit mon_on;

  logic [NUM_CH*DATA_W-1:0] cap_ch;
  logic [DATA_W-1:0]        cap_mix;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_ch(input int i, input int n);
    return tbl_m[(m_ph[i] + n * m_st[i]) % DEPTH];
  endfunction

  function automatic int exp_mix(input int n);
    int s = 0;
    for (int i = 0; i < NUM_CH; i++) s += exp_ch(i, n);
    return s / NUM_CH;
  endfunction

  function automatic int chv(input logic [NUM_CH*DATA_W-1:0] v, input int i);
    return int'(v[i*DATA_W +: DATA_W]);
  endfunction

  // Stream compare: every valid sample must be the next one in sequence.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_on && m_valid) begin
      if (m_len != 0 && acc_n >= m_len) begin
        chk("extra sample", acc_n, m_len - 1);
      end else begin
        for (int i = 0; i < NUM_CH; i++)
          chk($sformatf("stream ch%0d s%0d", i, acc_n),
              chv(m_ch, i), exp_ch(i, acc_n));
        chk($sformatf("stream mix s%0d", acc_n), int'(m_mix), exp_mix(acc_n));
        if (m_ready) acc_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int p0, input int p1, input int s0,
                           input int s1, input int len);
    cfg_phase = {ADDR_W'(p1), ADDR_W'(p0)};
    cfg_step  = {ADDR_W'(s1), ADDR_W'(s0)};
    cfg_len   = LEN_W'(len);
    m_ph[0] = p0; m_ph[1] = p1;
    m_st[0] = s0; m_st[1] = s1;
    m_len    = len;
    acc_n    = 0;
    done_cnt = 0;
    mon_on   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic take();
    int n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    chk("take valid", int'(m_valid), 1);
    cap_ch  = m_ch;
    cap_mix = m_mix;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    cfg_step = '0; cfg_phase = '0; cfg_len = '0;
    start = 1'b0; stop = 1'b0; m_ready = 1'b0;
    mon_on = 1'b0; acc_n = 0; done_cnt = 0; m_len = 0;
    for (int k = 0; k < DEPTH; k++) tbl_m[k] = 3000 + (k * 97) % 9000;
    tbl_m[0] = 7500; tbl_m[1] = 7688; tbl_m[15] = 10266;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst m_valid", int'(m_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst cfg_err", int'(cfg_err), 0);
    chk("rst m_mix", int'(m_mix), 0);
    chk("rst m_ch", int'(m_ch), 0);

    for (int k = 0; k < DEPTH; k++) begin
      tbl_we = 1'b1; tbl_addr = ADDR_W'(k); tbl_data = DATA_W'(tbl_m[k]);
      tick();
    end
    tbl_addr = ADDR_W'(1000); tbl_data = 16'hDEAD;
    tick();
    tbl_we = 1'b0;

    // Team table, step {15,1}, len 4, full throughput
    m_ready = 1'b1;
    start_run(0, 0, 1, 15, 4);
    chk("lat m_valid", int'(m_valid), 1);
    chk("lat busy", int'(busy), 1);
    chk("s0 ch0", chv(m_ch, 0), 7500);
    chk("s0 ch1", chv(m_ch, 1), 7500);
    chk("s0 mix", int'(m_mix), 7500);
    tick();
    chk("s1 ch0", chv(m_ch, 0), 7688);
    chk("s1 ch1", chv(m_ch, 1), 10266);
    chk("s1 mix", int'(m_mix), 8977);
    tick();
    tick();
    tick();
    chk("len4 done", int'(done), 1);
    chk("len4 valid off", int'(m_valid), 0);
    chk("len4 busy off", int'(busy), 0);
    tick();
    chk("len4 done pulse", int'(done), 0);
    chk("len4 accepts", acc_n, 4);
    chk("len4 done count", done_cnt, 1);

    // Full period against the table
    start_run(0, 250, 1, 1, 500);
    repeat (505) tick();
    chk("full accepts", acc_n, 500);
    chk("full done count", done_cnt, 1);

    // Reset mid-burst, then re-run from the surviving table
    start_run(0, 0, 1, 1, 0);
    repeat (5) tick();
    chk("mid m_valid", int'(m_valid), 1);
    mon_on = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst m_valid", int'(m_valid), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst m_mix", int'(m_mix), 0);
    tick();
    chk("midrst no done", int'(done), 0);
    start_run(0, 0, 1, 15, 2);
    chk("rerun s0 ch0", chv(m_ch, 0), 7500);
    tick();
    chk("rerun s1 ch1", chv(m_ch, 1), 10266);
    chk("rerun s1 mix", int'(m_mix), 8977);
    repeat (3) tick();
    chk("rerun done count", done_cnt, 1);

    // Index wrap
    m_ready = 1'b0;
    start_run(499, 495, 1, 15, 3);
    take();
    chk("wrap s0 ch0", chv(cap_ch, 0), tbl_m[499]);
    chk("wrap s0 ch1", chv(cap_ch, 1), tbl_m[495]);
    take();
    chk("wrap s1 ch0", chv(cap_ch, 0), tbl_m[0]);
    chk("wrap s1 ch1", chv(cap_ch, 1), tbl_m[10]);
    take();
    chk("wrap s2 ch0", chv(cap_ch, 0), tbl_m[1]);
    chk("wrap s2 ch1", chv(cap_ch, 1), tbl_m[25]);
    tick();
    chk("wrap done count", done_cnt, 1);

    // Backpressure after sample1
    start_run(0, 0, 1, 15, 6);
    take();
    take();
    for (int c = 0; c < 5; c++) begin
      chk("stall valid", int'(m_valid), 1);
      chk("stall ch0", chv(m_ch, 0), tbl_m[2]);
      chk("stall ch1", chv(m_ch, 1), tbl_m[30]);
      chk("stall mix", int'(m_mix), (tbl_m[2] + tbl_m[30]) / 2);
      tick();
    end
    m_ready = 1'b1;
    repeat (6) tick();
    m_ready = 1'b0;
    chk("bp accepts", acc_n, 6);
    chk("bp done count", done_cnt, 1);
    chk("bp busy", int'(busy), 0);

    // Illegal step rejected, sticky error, cleared by a good start
    mon_on = 1'b0;
    cfg_step = {10'd1, 10'd500}; cfg_phase = '0; cfg_len = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad cfg_err", int'(cfg_err), 1);
    chk("bad busy", int'(busy), 0);
    chk("bad m_valid", int'(m_valid), 0);
    tick();
    chk("bad cfg_err sticky", int'(cfg_err), 1);
    m_ready = 1'b1;
    start_run(0, 0, 1, 1, 1);
    chk("good cfg_err clr", int'(cfg_err), 0);
    chk("good busy", int'(busy), 1);
    repeat (2) tick();
    chk("good done count", done_cnt, 1);

    // start with stop in IDLE: nothing starts
    mon_on = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop busy", int'(busy), 0);
    chk("startstop valid", int'(m_valid), 0);

    // Continuous run, table write locked, stop under backpressure
    start_run(0, 100, 3, 7, 0);
    repeat (8) tick();
    tbl_we = 1'b1; tbl_addr = 10'd3; tbl_data = 16'h1234;
    tick();
    tbl_we = 1'b0;
    repeat (3) tick();
    m_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop m_valid", int'(m_valid), 0);
    chk("stop busy", int'(busy), 0);
    chk("stop done", int'(done), 0);
    tick();
    chk("stop done count", done_cnt, 0);
    chk("cont accepts", acc_n, 12);

    // DC readback of entry 3
    start_run(3, 3, 0, 0, 2);
    take();
    chk("dc s0 ch0", chv(cap_ch, 0), tbl_m[3]);
    chk("dc s0 ch1", chv(cap_ch, 1), 3291);
    take();
    chk("dc s1 ch0", chv(cap_ch, 0), 3291);
    tick();
    chk("dc done count", done_cnt, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/lms_tone_source.md
Name: lms_tone_source

Overview:
Parametrised multi-channel sine stimulus source for the LMS filter test path. It holds a runtime-loadable single-period waveform table. Each of NUM_CH channels walks the table with its own programmable step and start phase, so every tone is an integer multiple of the table fundamental. Each sample carries all channel values plus their average (tone mix), on a valid/ready stream with a programmable burst length.

Parameters:
DATA_W, 16, sample width (unsigned, offset-binary)
DEPTH, 500, table entries (one full period); 2 <= DEPTH <= 2**ADDR_W
ADDR_W, 10, table/phase index width
NUM_CH, 2, channel count; power of two in {1,2,4,8}
LEN_W, 16, burst-length counter width

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
tbl_we  in  1  table write strobe; ignored while busy=1
tbl_addr  in  ADDR_W  table write index; writes with tbl_addr >= DEPTH dropped
tbl_data  in  DATA_W  table write data
cfg_step  in  NUM_CH*ADDR_W  per-channel index increment, ch0 in LSBs
cfg_phase  in  NUM_CH*ADDR_W  per-channel start index
cfg_len  in  LEN_W  samples per burst; 0 = continuous
start  in  1  begin burst (sampled only in IDLE)
stop  in  1  abort burst
m_valid  out  1  sample available
m_ready  in  1  consumer accepts sample
m_ch  out  NUM_CH*DATA_W  per-channel samples, ch0 in LSBs
m_mix  out  DATA_W  channel average
busy  out  1  high in RUN
done  out  1  one-cycle pulse when a burst completes
cfg_err  out  1  sticky; set when start is rejected

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE. m_valid, busy, done, cfg_err, m_ch, m_mix, the index registers and the sample counter all clear to 0. Table contents are not reset. Reset mid-burst aborts it with no done pulse.
- Table: DEPTH x DATA_W register array, combinational read. A write lands at the edge and is visible to the next read.
- FSM IDLE -> RUN: start=1 in IDLE. Every cfg_step[i] and cfg_phase[i] must be < DEPTH. If any is not, stay IDLE, set cfg_err, keep cfg_err until the next accepted start (which clears it).
- On an accepted start: idx[i] <= cfg_phase[i], count <= 0, busy <= 1. Configuration is latched. Changes to cfg_* during RUN have no effect.
- Load condition in RUN: load = (!m_valid || m_ready) && !last_issued.
  - m_ch[i] <= table[idx[i]].
  - m_mix <= (sum of all channels) >> log2(NUM_CH). The sum uses DATA_W+log2(NUM_CH) bits; truncate, no rounding. NUM_CH=1 gives m_mix = m_ch.
  - m_valid <= 1.
  - idx[i] <= idx[i]+step[i], minus DEPTH if the result is >= DEPTH (single-subtract wrap).
  - count increments.
- Latency: first sample valid on the cycle after the accepted start edge. Full throughput is 1 sample/clk while m_ready=1.
- Backpressure: while m_valid && !m_ready, m_ch, m_mix and idx hold.
- Burst end, cfg_len=N>0: exactly N samples are issued. last_issued is set when the N-th sample is loaded. When that sample is accepted (m_valid && m_ready): m_valid <= 0, done <= 1 for one cycle, state -> IDLE, busy <= 0.
- cfg_len=0: continuous; count wraps silently; no done.
- stop=1 in RUN: next edge m_valid <= 0, pending sample discarded, state -> IDLE, busy <= 0, no done.
  - stop and a final accept in the same cycle: done still pulses.
  - stop in IDLE: no effect.
  - start and stop together in IDLE: stop wins, nothing starts.
- start while busy is ignored. tbl_we while busy is ignored (no write).
- step=0 is legal (DC output of table[phase]).

Test Plan:
1. Reset with m_valid=1 mid-burst -> next cycle m_valid=0, busy=0, done=0, m_mix=0. Table contents survive (re-run reads the same values).
2. Load the team 2 MHz table (table[0]=7500, table[1]=7688, table[15]=10266), NUM_CH=2, step={15,1}, phase={0,0}, len=4, m_ready=1 -> m_valid on cycle 1 after start. Samples:
   - sample0: ch0=7500, ch1=7500, mix=7500
   - sample1: ch0=7688, ch1=10266, mix=8977
   - then done pulses once with the 4th accept.
   A full 500-sample run matches the team's noisy table entry-for-entry.
3. Wrap: ch1 step=15, phase=495 -> second sample index 10, third index 25. phase=499, step=1 -> index 0 next.
4. Backpressure: m_ready low for 5 cycles after sample1 -> m_ch, m_mix stable. On release the sequence resumes with sample2, and no samples are lost or duplicated (exactly len accepts).
5. cfg_step=500 with DEPTH=500 -> start ignored, cfg_err=1, busy=0. A later valid start clears cfg_err.
6. Continuous mode, len=0; assert stop together with m_ready=0 -> m_valid drops next cycle, no done. tbl_we during RUN leaves table unchanged.
